// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder arbiter: FSM encoding, datapath width
// and the requester-ID width derivation.
package adder_arb_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic int id_width(input int n_req);
        return $clog2(n_req);
    endfunction

endpackage

// File: rtl/adder_arbiter_rr_grant.sv
// Round-robin pick: scans from last_i+1 upward with wrap and grants the
// first asserted request as a one-hot vector plus its index.
module rr_grant #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    // Rotating priority search, first hit wins
    always_comb begin
        int  k;
        logic found;
        k     = 32'sd0;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int off = 32'sd1; off <= N_REQ; off++) begin
            k = (int'(last_i) + off) % N_REQ;
            if (req_i[k] && !found) begin
                gnt_o[k] = 1'b1;
                idx_o    = ID_W'(k);
                found    = 1'b1;
            end else begin
                found    = found;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/yontem2.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups chained on group
// generate/propagate. No carry-in; the final carry-out is discarded.
module yontem2 (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic [63:0] sum_o
);

    logic [63:0] g_s;
    logic [63:0] p_s;
    logic [63:0] c_s;

    assign g_s = a_i & b_i;
    assign p_s = a_i ^ b_i;

    // Per-group lookahead carries, group carry forwarded by G/P
    always_comb begin
        logic cg;
        cg  = 1'b0;
        c_s = '0;
        for (int j = 0; j < 16; j++) begin
            c_s[4*j]   = cg;
            c_s[4*j+1] = g_s[4*j] | (p_s[4*j] & cg);
            c_s[4*j+2] = g_s[4*j+1] | (p_s[4*j+1] & g_s[4*j])
                       | (p_s[4*j+1] & p_s[4*j] & cg);
            c_s[4*j+3] = g_s[4*j+2] | (p_s[4*j+2] & g_s[4*j+1])
                       | (p_s[4*j+2] & p_s[4*j+1] & g_s[4*j])
                       | (p_s[4*j+2] & p_s[4*j+1] & p_s[4*j] & cg);
            cg = g_s[4*j+3] | (p_s[4*j+3] & g_s[4*j+2])
               | (p_s[4*j+3] & p_s[4*j+2] & g_s[4*j+1])
               | (p_s[4*j+3] & p_s[4*j+2] & p_s[4*j+1] & g_s[4*j])
               | (p_s[4*j+3] & p_s[4*j+2] & p_s[4*j+1] & p_s[4*j] & cg);
        end
    end

    assign sum_o = p_s ^ c_s;

endmodule

// File: rtl/adder_arbiter.sv
// Shares a single 64-bit adder between N_REQ requesters: round-robin accept,
// registered operands, one calculation cycle, valid/ready response.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [DATA_W*N_REQ-1:0] req_num1_i,
    input  logic [DATA_W*N_REQ-1:0] req_num2_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_W-1:0]       rsp_sum_o,
    output logic [ID_W-1:0]         rsp_id_o,
    output logic                    busy_o
);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   op1_q, op1_d;
    logic [DATA_W-1:0]   op2_q, op2_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                rsp_valid_q;
    logic                busy_q;

    logic [DATA_W-1:0]   add_s;
    logic [N_REQ-1:0]    gnt_s;
    logic [ID_W-1:0]     gnt_idx_s;
    logic                gnt_any_s;
    logic [N_REQ-1:0]    req_ready_s;

    rr_grant #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_grant (
        .req_i  (req_valid_i),
        .last_i (last_q),
        .gnt_o  (gnt_s),
        .idx_o  (gnt_idx_s),
        .any_o  (gnt_any_s)
    );

    yontem2 u_adder (
        .a_i   (op1_q),
        .b_i   (op2_q),
        .sum_o (add_s)
    );

    // Next-state and datapath selection
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        sum_d       = sum_q;
        rsp_id_d    = rsp_id_q;
        req_ready_s = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready_s = gnt_s;
                if (gnt_any_s) begin
                    op1_d   = req_num1_i[int'(gnt_idx_s)*DATA_W +: DATA_W];
                    op2_d   = req_num2_i[int'(gnt_idx_s)*DATA_W +: DATA_W];
                    id_d    = gnt_idx_s;
                    last_d  = gnt_idx_s;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                sum_d    = add_s;
                rsp_id_d = id_q;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            last_q      <= ID_W'(N_REQ - 1);
            id_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            sum_q       <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            sum_q       <= sum_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= (state_d == ST_RESP);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign req_ready_o = req_ready_s;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_sum_o   = sum_q;
    assign rsp_id_o    = rsp_id_q;
    assign busy_o      = busy_q;

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one 64-bit carry-lookahead adder datapath between N_REQ independent requesters.
- Selects requesters round-robin, latches the winner's operands and sequences the add.
- Registers the sum and returns it with the requester ID over a valid/ready response channel.
- Sits between the operand-producing blocks and the single adder instance, so the adder is never duplicated.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of the requester ID; must equal ceil(log2(N_REQ)).

Ports:
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_valid_i  input  N_REQ  per-requester request valid.
- req_num1_i  input  64*N_REQ  first operand; requester k occupies bits [64k+63:64k].
- req_num2_i  input  64*N_REQ  second operand, same packing as req_num1_i.
- req_ready_o  output  N_REQ  one-hot accept; a transfer occurs when req_valid_i[k] and req_ready_o[k] are both high.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response consumer ready.
- rsp_sum_o  output  64  (num1 + num2) mod 2^64.
- rsp_id_o  output  ID_W  index of the requester that owns rsp_sum_o.
- busy_o  output  1  high whenever the block is not in IDLE.

Behaviour:
- Reset:
  - Synchronous, active-high; takes effect at the clock edge with rst_i=1.
  - After reset: state=IDLE, req_ready_o=0, rsp_valid_o=0, rsp_sum_o=0, rsp_id_o=0, busy_o=0.
  - Round-robin pointer last_grant=N_REQ-1, so requester 0 wins first.
- State machine, 3 states:
  - IDLE:
    - req_ready_o = one-hot grant, combinational from req_valid_i and last_grant.
    - Search starts at last_grant+1 modulo N_REQ, wraps, and picks the first valid requester.
    - If any requester is valid, latch its operands into op1_q/op2_q, the winner index into id_q, set last_grant=winner, and go to CALC.
    - If none is valid, req_ready_o=0 and stay in IDLE.
  - CALC:
    - req_ready_o=0.
    - Adder output from op1_q/op2_q is captured into rsp_sum_o; id_q goes to rsp_id_o.
    - Go to RESP.
  - RESP:
    - rsp_valid_o=1; rsp_sum_o and rsp_id_o are held stable.
    - When rsp_ready_i=1, clear rsp_valid_o at the next edge and return to IDLE.
    - Otherwise stay in RESP.
- Latency and throughput:
  - Accept edge T gives rsp_valid_o=1 from T+2.
  - With rsp_ready_i held high, one accept every 3 cycles.
  - No new request is accepted until the response handshake completes.
- Requester rules:
  - Must hold valid and operands stable until accepted.
  - May drop valid before being accepted with no side effect.
  - The grant never goes to a requester whose valid is low in the accept cycle.
- Arithmetic:
  - 64-bit unsigned, no carry-in; carry-out is discarded, so results wrap modulo 2^64.
  - Operands are registered before the adder, so the adder path is isolated from requester timing.
- Fairness: when all requesters are continuously valid, the grant order is 0,1,...,N_REQ-1,0,...
- Reset mid-operation:
  - Any in-flight operation is discarded, with no response emitted.
  - State returns to IDLE and last_grant to N_REQ-1.
- busy_o = (state != IDLE), registered.
- rsp_sum_o and rsp_id_o keep their last values outside RESP; they are only meaningful when rsp_valid_o=1.

Decomposition:
- Shared header/package adder_arb_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_CALC=2'd1, ST_RESP=2'd2;
  - DATA_W=64;
  - the ID_W derivation.
- Sub-modules:
  - The existing 64-bit carry-lookahead adder module (yontem2) is instantiated once, unmodified.
  - A round-robin grant function/sub-module, rr_grant (inputs req and last_grant; outputs one-hot grant and index), is the natural split.

Test Plan:
1. Single request: requester 2 presents num1=5, num2=7, rsp_ready_i=1 -> req_ready_o=4'b0100 for one cycle; rsp_valid_o rises 2 cycles later with rsp_sum_o=12, rsp_id_o=2.
2. Wrap-around: num1=64'hFFFF_FFFF_FFFF_FFFF, num2=1 -> rsp_sum_o=0; num1=num2=64'h8000_0000_0000_0000 -> rsp_sum_o=0.
3. Round-robin: all 4 requesters valid continuously with distinct operands, rsp_ready_i=1 -> rsp_id_o sequence 0,1,2,3,0, each response 3 cycles apart.
4. Backpressure: hold rsp_ready_i=0 for 5 cycles in RESP while requester 1 is valid -> rsp_valid_o, rsp_sum_o and rsp_id_o stay stable and req_ready_o=0; accept of requester 1 occurs on the first IDLE cycle after rsp_ready_i=1.
5. Reset mid-CALC: assert rst_i for 1 cycle in CALC -> no rsp_valid_o pulse; all outputs 0; next simultaneous request from 0 and 3 grants requester 0.
6. Withdrawn request: requester 3 pulses valid only while the block is busy and deasserts before IDLE -> requester 3 is never granted and no response carries ID 3.
